// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit scheduler.
//   state_t            - scheduler FSM states (WAIT_LINK, READY, PACE)
//   FRAME_BITS_DEFAULT - bit-times reserved per issued byte
//   PACE_W             - width of the pacing down-counter
//   rate_cycles()      - UART rate output -> clock cycles per bit
package uart_pkg;

  typedef enum logic [1:0] {
    WAIT_LINK = 2'd0,
    READY     = 2'd1,
    PACE      = 2'd2
  } state_t;

  localparam int FRAME_BITS_DEFAULT = 12;

  // 15 bit-times * 2048 cycles per bit = 30720 fits in 16 bits.
  localparam int PACE_W = 16;

  // The UART reports cntmax[10:3]; the low three bits are always ones,
  // so one bit lasts {rate,3'b111}+1 cycles (8..2048).
  function automatic logic [11:0] rate_cycles(input logic [7:0] rate);
    return {1'b0, rate, 3'b111} + 12'd1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester and UART-facing signals of the scheduler.
//   req[NREQ]       - per-requester byte valid, held with data until gnt
//   data[NREQ*8]    - per-requester byte, requester i on [8i+7:8i]
//   gnt[NREQ]       - one-hot accept pulse
//   uart_rate[8]    - UART bit-rate report (cntmax[10:3])
//   uart_dix        - UART receive strobe
//   uart_od[8]      - byte handed to the UART
//   uart_dox        - one-cycle send strobe
// slave is the scheduler side, master the producer/UART side.
interface uart_tx_sched_if #(
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] data;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        uart_rate;
  logic              uart_dix;
  logic [7:0]        uart_od;
  logic              uart_dox;

  modport slave (
    input  req, data, uart_rate, uart_dix,
    output gnt, uart_od, uart_dox
  );

  modport master (
    output req, data, uart_rate, uart_dix,
    input  gnt, uart_od, uart_dox
  );

endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock byte FIFO with show-ahead output.
//   clk, nreset - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write din when not full
//   pop         - drop the head entry when not empty
//   dout        - current head entry (valid when !empty)
//   level       - occupancy 0..DEPTH
//   full, empty - occupancy flags
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between NREQ byte producers.
//   clk, nreset - clock, asynchronous active-low reset
//   bus         - uart_tx_sched_if.slave: req/data/gnt from the producers,
//                 uart_rate/uart_dix from the UART, uart_od/uart_dox to it
//   link_up     - set once the UART has received its first byte (auto-baud)
//   fifo_level  - TX FIFO occupancy
//   busy        - FIFO non-empty or a frame is still being paced out
// Round-robin arbitration pushes accepted bytes into a FIFO; the FSM issues
// them one at a time and waits FRAME_BITS bit-times between issues.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          nreset,
  uart_tx_sched_if.slave                bus,
  output logic                          link_up,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int PTR_W = $clog2(NREQ);

  state_t            state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [NREQ-1:0]   gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W:0]    cand;
  logic              found;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_din;
  logic [7:0]        fifo_dout;
  logic [PACE_W-1:0] pace_cnt;
  logic [PACE_W-1:0] pace_load;

  // Walk the requesters starting at rr_ptr, wrapping modulo NREQ (which
  // need not be a power of two). Full is judged on the registered level,
  // so a pop in the same cycle never frees a slot for a grant.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NREQ)) cand = cand - (PTR_W+1)'(NREQ);
      if (!found && nreset && !fifo_full && bus.req[cand[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[PTR_W-1:0]]  = 1'b1;
        gnt_idx               = cand[PTR_W-1:0];
      end
    end
  end

  assign bus.gnt  = gnt;
  assign push     = found;
  assign fifo_din = bus.data[8*gnt_idx +: 8];
  assign pop      = (state == READY) && !fifo_empty;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  uart_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (push),
    .pop    (pop),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Cycles reserved for one frame, using the rate seen in the issue cycle.
  assign pace_load = PACE_W'(FRAME_BITS) * PACE_W'(rate_cycles(bus.uart_rate));

  // WAIT_LINK leaves on the same strobe that sets link_up, so READY and
  // link_up become visible together and a queued byte issues the cycle
  // after. PACE returns to READY after pace_load cycles, making
  // back-to-back issues pace_load+1 cycles apart.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= WAIT_LINK;
      link_up      <= 1'b0;
      bus.uart_od  <= 8'h00;
      bus.uart_dox <= 1'b0;
      pace_cnt     <= '0;
    end else begin
      bus.uart_dox <= 1'b0;
      if (bus.uart_dix) link_up <= 1'b1;
      case (state)
        WAIT_LINK: begin
          if (link_up || bus.uart_dix) state <= READY;
        end
        READY: begin
          if (!fifo_empty) begin
            bus.uart_od  <= fifo_dout;
            bus.uart_dox <= 1'b1;
            pace_cnt     <= pace_load;
            state        <= PACE;
          end
        end
        PACE: begin
          if (pace_cnt <= PACE_W'(1)) begin
            pace_cnt <= '0;
            state    <= READY;
          end else begin
            pace_cnt <= pace_cnt - PACE_W'(1);
          end
        end
        default: state <= WAIT_LINK;
      endcase
    end
  end

  assign busy = (fifo_level != '0) || (state == PACE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: self-checking bench for uart_tx_sched.
// A queue-based model runs on every falling edge and compares all DUT
// outputs; directed sequences add literal expectations for pre-link
// queueing, pacing, round robin, the full boundary, maximum rate and reset
// in the middle of a pacing interval, followed by a randomized run.
module tb_uart_tx_sched;

  localparam int NREQ       = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_BITS = 12;

  logic       clk = 1'b0;
  logic       nreset;
  logic       link_up;
  logic [3:0] fifo_level;
  logic       busy;

  uart_tx_sched_if #(.NREQ(NREQ)) bus ();

  uart_tx_sched #(
    .NREQ       (NREQ),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_BITS (FRAME_BITS)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .bus        (bus),
    .link_up    (link_up),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a byte queue, the round-robin pointer, the link flag,
  // and the earliest cycle at which the next byte may be issued.
  logic [7:0] m_q[$];
  bit         m_link;
  int         m_ptr;
  bit         m_dox;
  logic [7:0] m_od;
  longint     m_block;
  longint     cyc = 0;

  always @(negedge clk) begin : model
    logic [NREQ-1:0] exp_gnt;
    int              gi;
    int              r;
    bit              issue;
    longint          p;
    cyc++;
    if (!nreset) begin
      m_q.delete();
      m_link  = 1'b0;
      m_ptr   = 0;
      m_dox   = 1'b0;
      m_od    = 8'h00;
      m_block = 0;
      checkOutput("rst_gnt", bus.gnt, 0);
      checkOutput("rst_dox", bus.uart_dox, 0);
      checkOutput("rst_od", bus.uart_od, 0);
      checkOutput("rst_link", link_up, 0);
      checkOutput("rst_level", fifo_level, 0);
      checkOutput("rst_busy", busy, 0);
    end else begin
      exp_gnt = '0;
      gi      = -1;
      if (m_q.size() < FIFO_DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          r = (m_ptr + k) % NREQ;
          if (gi < 0 && bus.req[r]) gi = r;
        end
      end
      if (gi >= 0) exp_gnt[gi] = 1'b1;
      checkOutput("model_gnt", bus.gnt, exp_gnt);
      checkOutput("model_dox", bus.uart_dox, m_dox);
      checkOutput("model_od", bus.uart_od, m_od);
      checkOutput("model_link", link_up, m_link);
      checkOutput("model_level", fifo_level, m_q.size());
      checkOutput("model_busy", busy, (m_q.size() != 0 || cyc < m_block) ? 1 : 0);
      issue = m_link && (cyc >= m_block) && (m_q.size() != 0);
      if (issue) begin
        p       = FRAME_BITS * (longint'(bus.uart_rate) * 8 + 8);
        m_od    = m_q.pop_front();
        m_dox   = 1'b1;
        m_block = cyc + 1 + p;
      end else begin
        m_dox = 1'b0;
      end
      if (bus.uart_dix) m_link = 1'b1;
      if (gi >= 0) begin
        m_q.push_back(bus.data[8*gi +: 8]);
        m_ptr = (gi + 1) % NREQ;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    next_cycle();
    nreset       = 1'b0;
    bus.req      = '0;
    bus.uart_dix = 1'b0;
    #1;
    checkOutput({tag, "_rst_dox"}, bus.uart_dox, 0);
    checkOutput({tag, "_rst_link"}, link_up, 0);
    checkOutput({tag, "_rst_level"}, fifo_level, 0);
    observe();
    next_cycle();
    nreset = 1'b1;
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    bit done = 1'b0;
    bus.req[idx]          = 1'b1;
    bus.data[8*idx +: 8]  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      observe();
      if (bus.gnt[idx]) done = 1'b1;
      next_cycle();
    end
    bus.req[idx] = 1'b0;
    if (!done) checkOutput("send_timeout", 0, 1);
  endtask

  task automatic wait_pulse(input string name, input int budget,
                            output longint t, output logic [7:0] od);
    bit found = 1'b0;
    t  = 0;
    od = 8'h00;
    for (int i = 0; i < budget && !found; i++) begin
      observe();
      if (bus.uart_dox) begin
        found = 1'b1;
        t     = $time;
        od    = bus.uart_od;
      end
      next_cycle();
    end
    if (!found) checkOutput({name, "_timeout"}, 0, 1);
  endtask

  task automatic applyStimulus(input int c, input logic [NREQ-1:0] g_prev);
    nreset = (c != 2000);
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req[i] || g_prev[i]) begin
        bus.req[i]          = ($urandom_range(0, 3) == 0);
        bus.data[8*i +: 8]  = 8'($urandom);
      end
    end
    bus.uart_dix = ($urandom_range(0, 299) == 0);
    if ($urandom_range(0, 499) == 0) bus.uart_rate = 8'($urandom_range(0, 2));
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] rr_dat [5] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0};

  initial begin
    int              cnt;
    longint          t1;
    longint          t2;
    logic [7:0]      od1;
    logic [7:0]      od2;
    logic [NREQ-1:0] g_prev;

    nreset        = 1'b0;
    bus.req       = '0;
    bus.data      = '0;
    bus.uart_rate = 8'd0;
    bus.uart_dix  = 1'b0;

    // Pre-link queueing
    do_reset("init");
    bus.data[7:0] = 8'h41;
    bus.req[0]    = 1'b1;
    observe();
    checkOutput("pl_gnt", bus.gnt, 4'b0001);
    next_cycle();
    bus.req[0] = 1'b0;
    observe();
    checkOutput("pl_level", fifo_level, 1);
    cnt = 0;
    repeat (1000) begin
      next_cycle();
      observe();
      if (bus.uart_dox) cnt++;
    end
    checkOutput("pl_no_dox", cnt, 0);
    checkOutput("pl_link_low", link_up, 0);
    next_cycle();
    bus.uart_dix = 1'b1;
    observe();
    checkOutput("pl_link_M", link_up, 0);
    next_cycle();
    bus.uart_dix = 1'b0;
    observe();
    checkOutput("pl_link_M1", link_up, 1);
    checkOutput("pl_dox_M1", bus.uart_dox, 0);
    next_cycle();
    observe();
    checkOutput("pl_dox_M2", bus.uart_dox, 1);
    checkOutput("pl_od_M2", bus.uart_od, 8'h41);
    checkOutput("pl_level_M2", fifo_level, 0);
    next_cycle();

    // Pacing at rate 54: 12 * 440 + 1 = 5281 cycles between pulses
    do_reset("pace");
    bus.uart_rate = 8'd54;
    bus.uart_dix  = 1'b1;
    next_cycle();
    bus.uart_dix = 1'b0;
    send(0, 8'h01);
    send(1, 8'h02);
    wait_pulse("pace1", 100, t1, od1);
    wait_pulse("pace2", 6000, t2, od2);
    checkOutput("pace_od1", od1, 8'h01);
    checkOutput("pace_od2", od2, 8'h02);
    checkOutput("pace_spacing", (t2 - t1) / 10, 5281);

    // Round robin with all requesters held
    do_reset("rr");
    bus.uart_rate = 8'd0;
    bus.data      = 32'hD3C2_B1A0;
    bus.req       = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      observe();
      checkOutput($sformatf("rr_gnt%0d", k), bus.gnt, rr_exp[k]);
      next_cycle();
    end
    bus.req      = '0;
    bus.uart_dix = 1'b1;
    next_cycle();
    bus.uart_dix = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_pulse("rr_pulse", 200, t1, od1);
      checkOutput($sformatf("rr_od%0d", k), od1, rr_dat[k]);
    end

    // Full boundary on requester 1
    do_reset("full");
    bus.req[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.data[15:8] = 8'(8'h10 + k);
      observe();
      checkOutput($sformatf("full_gnt%0d", k), bus.gnt, 4'b0010);
      next_cycle();
    end
    bus.data[15:8] = 8'h18;
    observe();
    checkOutput("full_gnt_blocked", bus.gnt, 0);
    checkOutput("full_level8", fifo_level, 8);
    checkOutput("full_busy", busy, 1);
    next_cycle();
    bus.uart_dix = 1'b1;
    observe();
    checkOutput("full_gnt_M", bus.gnt, 0);
    next_cycle();
    bus.uart_dix = 1'b0;
    observe();
    checkOutput("full_gnt_M1", bus.gnt, 0);
    checkOutput("full_level_M1", fifo_level, 8);
    next_cycle();
    observe();
    checkOutput("full_dox", bus.uart_dox, 1);
    checkOutput("full_od", bus.uart_od, 8'h10);
    checkOutput("full_level7", fifo_level, 7);
    checkOutput("full_gnt_refill", bus.gnt, 4'b0010);
    next_cycle();
    bus.data[15:8] = 8'h19;
    observe();
    checkOutput("full_level_back", fifo_level, 8);
    next_cycle();
    bus.req = '0;

    // Maximum rate: 12 * 2048 + 1 = 24577 cycles
    do_reset("max");
    bus.uart_rate = 8'd255;
    send(0, 8'h55);
    send(1, 8'hAA);
    bus.uart_dix = 1'b1;
    next_cycle();
    bus.uart_dix = 1'b0;
    wait_pulse("max1", 100, t1, od1);
    wait_pulse("max2", 25000, t2, od2);
    checkOutput("max_od1", od1, 8'h55);
    checkOutput("max_od2", od2, 8'hAA);
    checkOutput("max_spacing", (t2 - t1) / 10, 24577);

    // Reset in the middle of a pacing interval
    do_reset("mp_pre");
    bus.uart_rate = 8'd0;
    for (int k = 0; k < 4; k++) send(2, 8'(8'hC0 + k));
    bus.uart_dix = 1'b1;
    next_cycle();
    bus.uart_dix = 1'b0;
    wait_pulse("mp1", 100, t1, od1);
    checkOutput("mp_od1", od1, 8'hC0);
    repeat (10) begin
      observe();
      next_cycle();
    end
    observe();
    checkOutput("mp_busy_pace", busy, 1);
    checkOutput("mp_level3", fifo_level, 3);
    next_cycle();
    nreset = 1'b0;
    #1;
    checkOutput("mp_rst_dox", bus.uart_dox, 0);
    checkOutput("mp_rst_od", bus.uart_od, 0);
    checkOutput("mp_rst_link", link_up, 0);
    checkOutput("mp_rst_level", fifo_level, 0);
    checkOutput("mp_rst_busy", busy, 0);
    checkOutput("mp_rst_gnt", bus.gnt, 0);
    observe();
    next_cycle();
    nreset = 1'b1;
    observe();
    checkOutput("mp_link_after", link_up, 0);
    checkOutput("mp_level_after", fifo_level, 0);
    cnt = 0;
    repeat (200) begin
      next_cycle();
      observe();
      if (bus.uart_dox) cnt++;
    end
    checkOutput("mp_no_dox", cnt, 0);
    next_cycle();

    // Randomized traffic checked by the model
    do_reset("rand");
    g_prev = '0;
    for (int c = 0; c < 4000; c++) begin
      applyStimulus(c, g_prev);
      observe();
      g_prev = bus.gnt;
      next_cycle();
    end
    nreset  = 1'b1;
    bus.req = '0;
    observe();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
